// File: rtl/frame_buffer_scan.sv
// Double-buffered 32x32x3 frame store feeding the HUB75 driver; swaps banks only on frame_sync.
// Optional `AUTO_CLEAR_EN: after each swap the new back bank is refilled with CLR_VAL.
module frame_buffer_scan #(
  parameter int         COLS      = 32,
  parameter int         HALF_ROWS = 16,
  parameter logic [2:0] CLR_VAL   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [2:0] wr_rgb,
  input  logic       clr_req,
  input  logic       swap_req,
  output logic       swap_done,
  output logic       busy,
  input  logic       frame_sync,
  input  logic [3:0] rd_row,
  input  logic [4:0] rd_col,
  output logic [7:0] led_data
);

  localparam int DEPTH = 2 * HALF_ROWS * COLS;

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t     state;
  logic       front_sel;
  logic       pending_swap;
  logic [9:0] clr_cnt;

  logic [2:0] bank0 [DEPTH];
  logic [2:0] bank1 [DEPTH];

  logic       mem_we;
  logic [9:0] mem_addr;
  logic [2:0] mem_data;
  logic [9:0] top_addr;
  logic [9:0] bot_addr;

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign top_addr = {1'b0, rd_row, rd_col};
  assign bot_addr = {1'b1, rd_row, rd_col};

  // Single back-bank write port shared by pixel writes (IDLE) and the clear sweep.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = {wr_y, wr_x};
    mem_data = wr_rgb;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt;
      mem_data = CLR_VAL;
    end else if (state == IDLE && wr_valid) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (front_sel) bank0[mem_addr] <= mem_data;
      else           bank1[mem_addr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_data <= '0;
    end else if (front_sel) begin
      led_data <= {2'b00, bank1[top_addr], bank1[bot_addr]};
    end else begin
      led_data <= {2'b00, bank0[top_addr], bank0[bot_addr]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      front_sel    <= 1'b0;
      swap_done    <= 1'b0;
      pending_swap <= 1'b0;
      clr_cnt      <= '0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            pending_swap <= swap_req;
          end else if (swap_req) begin
            state <= SWAP_WAIT;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 10'd1;
          if (swap_req) pending_swap <= 1'b1;
          if (clr_cnt == 10'(DEPTH - 1)) begin
            // A swap_req landing on the final clear cycle still counts as pending.
            if (pending_swap || swap_req) begin
              state        <= SWAP_WAIT;
              pending_swap <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        SWAP_WAIT: begin
          if (frame_sync) begin
            front_sel <= ~front_sel;
            swap_done <= 1'b1;
`ifdef AUTO_CLEAR_EN
            state   <= CLEAR;
            clr_cnt <= '0;
`else
            state   <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_scan.sv
// Self-checking bench for frame_buffer_scan against a two-bank array model of the display store.
module tb_frame_buffer_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_rgb;
  logic       clr_req;
  logic       swap_req;
  logic       swap_done;
  logic       busy;
  logic       frame_sync;
  logic [3:0] rd_row;
  logic [4:0] rd_col;
  logic [7:0] led_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] mb [2][1024];
  int         mfront = 0;

  frame_buffer_scan #(.COLS(32), .HALF_ROWS(16), .CLR_VAL(3'b000)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb), .clr_req(clr_req),
    .swap_req(swap_req), .swap_done(swap_done), .busy(busy),
    .frame_sync(frame_sync), .rd_row(rd_row), .rd_col(rd_col), .led_data(led_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_led(input int r, input int c);
    logic [9:0] at;
    logic [9:0] ab;
    at = {1'b0, 4'(r), 5'(c)};
    ab = {1'b1, 4'(r), 5'(c)};
    return {2'b00, mb[mfront][at], mb[mfront][ab]};
  endfunction

  task automatic clear_model_back(input int upto);
    for (int i = 0; i < upto; i++) mb[1 - mfront][i] = 3'b000;
  endtask

  task automatic rd_check(input int r, input int c, input string name);
    logic [7:0] e;
    rd_row = 4'(r);
    rd_col = 5'(c);
    tick();
    e = exp_led(r, c);
    n_tests++;
    if (led_data !== e) begin
      n_fail++;
      $display("FAIL %s row=%0d col=%0d led_data=%h expected=%h", name, r, c, led_data, e);
    end
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int cnt = 0;
    while (busy !== 1'b0 && cnt < 3000) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cnt != exp_cycles) begin
      n_fail++;
      $display("FAIL %s busy cycles=%0d expected=%0d", name, cnt, exp_cycles);
    end
  endtask

  task automatic wr_px(input int x, input int y, input logic [2:0] rgb);
    n_tests++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ready_idle wr_ready=%b expected=1", wr_ready);
    end
    wr_valid = 1'b1;
    wr_x = 5'(x);
    wr_y = 5'(y);
    wr_rgb = rgb;
    tick();
    wr_valid = 1'b0;
    mb[1 - mfront][{5'(y), 5'(x)}] = rgb;
  endtask

  task automatic do_clear();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_idle("clear_len", 1024);
    clear_model_back(1024);
  endtask

  task automatic do_swap(input bit chk_old);
    int waits;
    int r;
    int c;
    logic [7:0] e;
    swap_req = 1'b1;
    frame_sync = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_sync = 1'b0;
    waits = $urandom_range(0, 4);
    for (int i = 0; i < waits; i++) begin
      n_tests++;
      if ({wr_ready, swap_done, busy} !== 3'b001) begin
        n_fail++;
        $display("FAIL swap_wait {wr_ready,swap_done,busy}=%b expected=001", {wr_ready, swap_done, busy});
      end
      clr_req = 1'($urandom_range(0, 1));
      swap_req = 1'($urandom_range(0, 1));
      tick();
      clr_req = 1'b0;
      swap_req = 1'b0;
    end
    r = $urandom_range(0, 15);
    c = $urandom_range(0, 31);
    rd_row = 4'(r);
    rd_col = 5'(c);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    n_tests++;
    if (swap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_done_pulse swap_done=%b expected=1", swap_done);
    end
    if (chk_old) begin
      e = exp_led(r, c);
      n_tests++;
      if (led_data !== e) begin
        n_fail++;
        $display("FAIL swap_old_front led_data=%h expected=%h", led_data, e);
      end
    end
`ifdef AUTO_CLEAR_EN
    n_tests++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_autoclr_ready wr_ready=%b expected=0", wr_ready);
    end
`else
    n_tests++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_idle_ready wr_ready=%b expected=1", wr_ready);
    end
`endif
    mfront = 1 - mfront;
    tick();
    e = exp_led(r, c);
    n_tests++;
    if (led_data !== e || swap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_new_front led_data=%h swap_done=%b expected=%h,0", led_data, swap_done, e);
    end
`ifdef AUTO_CLEAR_EN
    wait_idle("autoclr_len", 1023);
    clear_model_back(1024);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({led_data, wr_ready, busy, swap_done} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state led=%h rdy=%b busy=%b sd=%b expected=00,1,0,0",
               led_data, wr_ready, busy, swap_done);
    end
    reset = 1'b0;
    tick();
    mfront = 0;
  endtask

  task automatic test_clear_swap();
    do_clear();
    do_swap(1'b0);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++) begin
        rd_row = 4'(r);
        rd_col = 5'(c);
        tick();
        n_tests++;
        if (led_data !== 8'h00) begin
          n_fail++;
          $display("FAIL sweep_zero row=%0d col=%0d led_data=%h expected=00", r, c, led_data);
        end
      end
    do_clear();
  endtask

  task automatic test_known_pixel();
    wr_px(3, 2, 3'b101);
    wr_px(3, 18, 3'b011);
    do_swap(1'b1);
    rd_check(2, 3, "known_pixel_model");
    n_tests++;
    if (led_data !== 8'b00_101_011) begin
      n_fail++;
      $display("FAIL known_pixel led_data=%b expected=00101011", led_data);
    end
  endtask

  task automatic test_write_no_swap();
    for (int i = 0; i < 20; i++) begin
      int x = $urandom_range(0, 31);
      int y = $urandom_range(0, 31);
      wr_px(x, y, 3'($urandom_range(0, 7)));
      rd_check(y % 16, x, "write_no_swap");
    end
  endtask

  task automatic test_hold_write();
    int hx = $urandom_range(0, 31);
    int hy = $urandom_range(0, 31);
    logic [2:0] hrgb = 3'($urandom_range(1, 7));
    int waits = $urandom_range(1, 4);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wr_valid = 1'b1;
    wr_x = 5'(hx);
    wr_y = 5'(hy);
    wr_rgb = hrgb;
    for (int i = 0; i < waits; i++) begin
      n_tests++;
      if (wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_not_ready wr_ready=%b expected=0", wr_ready);
      end
      tick();
    end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    n_tests++;
    if (swap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_swap_done swap_done=%b expected=1", swap_done);
    end
    mfront = 1 - mfront;
`ifdef AUTO_CLEAR_EN
    begin
      int cnt = 0;
      while (wr_ready !== 1'b1 && cnt < 3000) begin
        tick();
        cnt++;
      end
      n_tests++;
      if (cnt != 1024) begin
        n_fail++;
        $display("FAIL autoclr_ready_low cycles=%0d expected=1024", cnt);
      end
      clear_model_back(1024);
    end
`else
    n_tests++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ready_after wr_ready=%b expected=1", wr_ready);
    end
`endif
    tick();
    wr_valid = 1'b0;
    mb[1 - mfront][{5'(hy), 5'(hx)}] = hrgb;
    rd_check(hy % 16, hx, "hold_front_untouched");
    do_swap(1'b1);
    rd_check(hy % 16, hx, "hold_write_landed");
  endtask

  task automatic test_clr_swap_together();
    int low_cnt = 0;
    int sd_cnt = 0;
    for (int i = 0; i < 8; i++)
      wr_px($urandom_range(0, 31), $urandom_range(0, 31), 3'($urandom_range(1, 7)));
    clr_req = 1'b1;
    swap_req = 1'b1;
    tick();
    clr_req = 1'b0;
    swap_req = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (busy !== 1'b1) low_cnt++;
      if (swap_done !== 1'b0) sd_cnt++;
      clr_req = (i == 300);
      frame_sync = (i == 500);
      tick();
      clr_req = 1'b0;
      frame_sync = 1'b0;
    end
    n_tests++;
    if (low_cnt != 0 || sd_cnt != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_swap_busy low=%0d sd=%0d busy_after=%b expected=0,0,1", low_cnt, sd_cnt, busy);
    end
    clear_model_back(1024);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    n_tests++;
    if (swap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_swap_done swap_done=%b expected=1", swap_done);
    end
    mfront = 1 - mfront;
`ifdef AUTO_CLEAR_EN
    wait_idle("clr_swap_autoclr", 1024);
    clear_model_back(1024);
`else
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_swap_idle busy=%b expected=0", busy);
    end
`endif
    for (int i = 0; i < 10; i++) rd_check($urandom_range(0, 15), $urandom_range(0, 31), "clr_swap_read");
  endtask

  task automatic test_reset_mid_clear();
    wr_px(19, 15, 3'b110);
    wr_px(20, 15, 3'b111);
    wr_px(0, 0, 3'b010);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({led_data, wr_ready, busy, swap_done} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_clear led=%h rdy=%b busy=%b sd=%b expected=00,1,0,0",
               led_data, wr_ready, busy, swap_done);
    end
    clear_model_back(500);
    mfront = 0;
    tick();
    reset = 1'b0;
    tick();
    rd_check(15, 19, "mid_clear_front0_a");
    rd_check(15, 20, "mid_clear_front0_b");
    for (int i = 0; i < 10; i++) rd_check($urandom_range(0, 15), $urandom_range(0, 31), "mid_clear_front0");
    do_swap(1'b1);
    rd_check(15, 19, "mid_clear_partial_a");
    rd_check(15, 20, "mid_clear_partial_b");
    rd_check(0, 0, "mid_clear_partial_c");
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 200; i++) begin
      int op = $urandom_range(0, 19);
      if (op < 10)
        wr_px($urandom_range(0, 31), $urandom_range(0, 31), 3'($urandom_range(0, 7)));
      else if (op < 19)
        rd_check($urandom_range(0, 15), $urandom_range(0, 31), "random_read");
      else
        do_swap(1'b1);
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_valid = 1'b0;
    wr_x = '0;
    wr_y = '0;
    wr_rgb = '0;
    clr_req = 1'b0;
    swap_req = 1'b0;
    frame_sync = 1'b0;
    rd_row = '0;
    rd_col = '0;
    test_reset();
    test_clear_swap();
    test_known_pixel();
    test_write_no_swap();
    test_hold_write();
    test_clr_swap_together();
    test_reset_mid_clear();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
